// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared constants and types for the camera parameter register block:
//   FP27_ONE       fp27 encoding of 1.0 (reset value of look_at diagonals)
//   ADDR_*         register indices (eye xyz, then look_at row-major)
//   NUM_CAM_REGS   number of implemented staging/active registers
//   cam_state_t    commit FSM states
//   cam_reset_val  reset value of a register given its index
// -----------------------------------------------------------------------------
package cam_pkg;

    localparam logic [26:0] FP27_ONE = 27'h1FC0000;

    localparam int unsigned NUM_CAM_REGS = 12;

    localparam logic [3:0] ADDR_EYE_X  = 4'd0;
    localparam logic [3:0] ADDR_EYE_Y  = 4'd1;
    localparam logic [3:0] ADDR_EYE_Z  = 4'd2;
    localparam logic [3:0] ADDR_LA_1_1 = 4'd3;
    localparam logic [3:0] ADDR_LA_1_2 = 4'd4;
    localparam logic [3:0] ADDR_LA_1_3 = 4'd5;
    localparam logic [3:0] ADDR_LA_2_1 = 4'd6;
    localparam logic [3:0] ADDR_LA_2_2 = 4'd7;
    localparam logic [3:0] ADDR_LA_2_3 = 4'd8;
    localparam logic [3:0] ADDR_LA_3_1 = 4'd9;
    localparam logic [3:0] ADDR_LA_3_2 = 4'd10;
    localparam logic [3:0] ADDR_LA_3_3 = 4'd11;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cam_state_t;

    // Identity matrix for look_at, zero eye position.
    function automatic logic [26:0] cam_reset_val(input logic [3:0] idx);
        if (idx == ADDR_LA_1_1 || idx == ADDR_LA_2_2 || idx == ADDR_LA_3_3)
            return FP27_ONE;
        return 27'd0;
    endfunction

endpackage

// File: rtl/cam_param_regs.sv
// -----------------------------------------------------------------------------
// cam_param_regs
// Double-buffered camera parameters for the raymarcher. Software writes a
// staging set; commit_req arms a publish that copies the whole staging set into
// the active set on the next frame_start, so a frame never sees a torn camera.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_en/addr/data     staging write (accepted only while wr_ready)
//   wr_ready            high in IDLE; writes while PENDING are dropped
//   wr_err              1-cycle pulse after an accepted write to addr 12-15
//   commit_req          arm a publish (ignored while already PENDING)
//   frame_start         frame boundary pulse; publishes if PENDING
//   eye_*, look_at_r_c  active parameter outputs (registered)
//   cfg_pending         a commit is waiting for frame_start
//   params_updated      1-cycle pulse after the active set was loaded
//   frame_count         free-running frame_start counter (wraps)
//
// Optional build macro CAM_PARAM_READBACK_EN adds rd_addr/rd_data: a registered
// read of staging[rd_addr], 0 for addresses beyond the implemented registers.
// -----------------------------------------------------------------------------
module cam_param_regs
    import cam_pkg::*;
#(
    parameter int DATA_W = 27,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_err,
    input  logic              commit_req,
    input  logic              frame_start,
    output logic [DATA_W-1:0] eye_x,
    output logic [DATA_W-1:0] eye_y,
    output logic [DATA_W-1:0] eye_z,
    output logic [DATA_W-1:0] look_at_1_1,
    output logic [DATA_W-1:0] look_at_1_2,
    output logic [DATA_W-1:0] look_at_1_3,
    output logic [DATA_W-1:0] look_at_2_1,
    output logic [DATA_W-1:0] look_at_2_2,
    output logic [DATA_W-1:0] look_at_2_3,
    output logic [DATA_W-1:0] look_at_3_1,
    output logic [DATA_W-1:0] look_at_3_2,
    output logic [DATA_W-1:0] look_at_3_3,
    output logic              cfg_pending,
    output logic              params_updated,
    output logic [FCNT_W-1:0] frame_count
`ifdef CAM_PARAM_READBACK_EN
   ,input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
`endif
);

    cam_state_t state, state_nx;
    logic       publish;
    logic       wr_acc;

    logic [DATA_W-1:0] staging [NUM_CAM_REGS];
    logic [DATA_W-1:0] active  [NUM_CAM_REGS];

    // ---- commit FSM --------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // A frame_start in IDLE never publishes, even alongside commit_req: the
    // commit only arms, and the next boundary does the copy.
    always_comb begin
        state_nx    = state;
        publish     = 1'b0;
        wr_ready    = 1'b0;
        cfg_pending = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (commit_req) state_nx = PENDING;
            end
            PENDING: begin
                cfg_pending = 1'b1;
                if (frame_start) begin
                    publish  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wr_acc = wr_en && wr_ready;

    // ---- staging / active registers, status ------------------------------
    // Reset restores both sets, which also discards any staged-but-unpublished
    // values from an interrupted commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAM_REGS; i++) begin
                staging[i] <= DATA_W'(cam_reset_val(4'(i)));
                active[i]  <= DATA_W'(cam_reset_val(4'(i)));
            end
            wr_err         <= 1'b0;
            params_updated <= 1'b0;
            frame_count    <= '0;
        end else begin
            wr_err <= wr_acc && (wr_addr > ADDR_LA_3_3);
            if (wr_acc && (wr_addr <= ADDR_LA_3_3))
                staging[wr_addr] <= wr_data;

            params_updated <= publish;
            if (publish) begin
                for (int i = 0; i < NUM_CAM_REGS; i++)
                    active[i] <= staging[i];
            end

            if (frame_start)
                frame_count <= frame_count + 1'b1;
        end
    end

    assign eye_x       = active[ADDR_EYE_X];
    assign eye_y       = active[ADDR_EYE_Y];
    assign eye_z       = active[ADDR_EYE_Z];
    assign look_at_1_1 = active[ADDR_LA_1_1];
    assign look_at_1_2 = active[ADDR_LA_1_2];
    assign look_at_1_3 = active[ADDR_LA_1_3];
    assign look_at_2_1 = active[ADDR_LA_2_1];
    assign look_at_2_2 = active[ADDR_LA_2_2];
    assign look_at_2_3 = active[ADDR_LA_2_3];
    assign look_at_3_1 = active[ADDR_LA_3_1];
    assign look_at_3_2 = active[ADDR_LA_3_2];
    assign look_at_3_3 = active[ADDR_LA_3_3];

`ifdef CAM_PARAM_READBACK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      rd_data <= '0;
        else if (rd_addr > ADDR_LA_3_3) rd_data <= '0;
        else                            rd_data <= staging[rd_addr];
    end
`else
    // Readback port not built.
`endif

endmodule

// File: tb/tb_cam_param_regs.sv
// -----------------------------------------------------------------------------
// tb_cam_param_regs
// Scoreboard bench: every publish predicted by the reference model pushes the
// expected active set; the monitor pops it on params_updated and compares all
// twelve outputs. Between publishes the active outputs must hold.
// -----------------------------------------------------------------------------
module tb_cam_param_regs;

    typedef logic [11:0][26:0] regset_t;

    localparam logic [26:0] ONE = 27'h1FC0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [26:0] wr_data;
    logic        wr_ready, wr_err;
    logic        commit_req, frame_start;
    logic [26:0] eye_x, eye_y, eye_z;
    logic [26:0] look_at_1_1, look_at_1_2, look_at_1_3;
    logic [26:0] look_at_2_1, look_at_2_2, look_at_2_3;
    logic [26:0] look_at_3_1, look_at_3_2, look_at_3_3;
    logic        cfg_pending, params_updated;
    logic [7:0]  frame_count;

    cam_param_regs dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_err(wr_err),
        .commit_req(commit_req), .frame_start(frame_start),
        .eye_x(eye_x), .eye_y(eye_y), .eye_z(eye_z),
        .look_at_1_1(look_at_1_1), .look_at_1_2(look_at_1_2), .look_at_1_3(look_at_1_3),
        .look_at_2_1(look_at_2_1), .look_at_2_2(look_at_2_2), .look_at_2_3(look_at_2_3),
        .look_at_3_1(look_at_3_1), .look_at_3_2(look_at_3_2), .look_at_3_3(look_at_3_3),
        .cfg_pending(cfg_pending), .params_updated(params_updated),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    regset_t dut_act;
    assign dut_act = {look_at_3_3, look_at_3_2, look_at_3_1,
                      look_at_2_3, look_at_2_2, look_at_2_1,
                      look_at_1_3, look_at_1_2, look_at_1_1,
                      eye_z, eye_y, eye_x};

    int n_cmp = 0;
    int n_bad = 0;
    int n_upd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---- reference model ---------------------------------------------------
    regset_t stg_m, act_m;
    regset_t sb[$];
    logic    pend_m;
    int      fc_exp;

    function automatic regset_t defaults();
        regset_t r = '0;
        r[3]  = ONE;
        r[7]  = ONE;
        r[11] = ONE;
        return r;
    endfunction

    // Monitor: pop on every params_updated, otherwise the active set must hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (params_updated) begin
                n_upd++;
                if (sb.size() == 0) begin
                    chk("upd_spurious", 32'd1, 32'd0);
                end else begin
                    act_m = sb.pop_front();
                    for (int i = 0; i < 12; i++)
                        chk($sformatf("pub_r%0d", i), 32'(dut_act[i]), 32'(act_m[i]));
                end
            end else begin
                int nbad_h;
                nbad_h = 0;
                for (int i = 0; i < 12; i++)
                    if (dut_act[i] !== act_m[i]) nbad_h++;
                if (nbad_h != 0) chk("act_hold", 32'(nbad_h), 32'd0);
            end
        end
    end

    // One clock of stimulus: drive at negedge, predict, check status after edge.
    task automatic drive(input logic we, input logic [3:0] a, input logic [26:0] d,
                         input logic cr, input logic fs);
        logic idle, exp_err;
        wr_en = we; wr_addr = a; wr_data = d; commit_req = cr; frame_start = fs;
        idle    = !pend_m;
        exp_err = we && idle && (a > 4'd11);
        if (we && idle && a <= 4'd11) stg_m[a] = d;
        if (idle && cr) pend_m = 1'b1;
        else if (!idle && fs) begin
            pend_m = 1'b0;
            sb.push_back(stg_m);
        end
        if (fs) fc_exp++;
        @(negedge clk);
        wr_en = 0; commit_req = 0; frame_start = 0;
        chk("wr_ready", 32'(wr_ready), 32'(!pend_m));
        chk("cfg_pending", 32'(cfg_pending), 32'(pend_m));
        chk("wr_err", 32'(wr_err), 32'(exp_err));
        chk("frame_count", 32'(frame_count), 32'(fc_exp % 256));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0; commit_req = 0; frame_start = 0;
        #1;
        chk("rst_cfg_pending", 32'(cfg_pending), 32'd0);
        chk("rst_eye_x", 32'(eye_x), 32'd0);
        chk("rst_la11", 32'(look_at_1_1), 32'(ONE));
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_params_updated", 32'(params_updated), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_la33", 32'(look_at_3_3), 32'(ONE));
        stg_m = defaults(); act_m = defaults();
        pend_m = 1'b0; fc_exp = 0;
        sb.delete();
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int u0;
        do_reset();
        // Reset release values.
        chk("rel_la11", 32'(look_at_1_1), 32'h1FC0000);
        chk("rel_la12", 32'(look_at_1_2), 32'd0);
        chk("rel_eye_x", 32'(eye_x), 32'd0);
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);

        // Basic write / commit / publish.
        u0 = n_upd;
        drive(1, 4'd0, 27'h0123456, 0, 0);
        drive(0, 4'd0, 27'h0, 1, 0);
        chk("pre_pub_eye_x", 32'(eye_x), 32'd0);
        drive(0, 4'd0, 27'h0, 0, 1);
        chk("pub_eye_x", 32'(eye_x), 32'h0123456);
        drive(0, 4'd0, 27'h0, 0, 0);
        drive(0, 4'd0, 27'h0, 0, 0);
        chk("upd_once", 32'(n_upd - u0), 32'd1);

        // Write + commit + frame_start in one IDLE cycle: arm only.
        u0 = n_upd;
        drive(1, 4'd1, 27'h00AAAAA, 1, 1);
        drive(0, 4'd0, 27'h0, 0, 0);
        chk("same_cyc_no_pub", 32'(n_upd - u0), 32'd0);
        chk("same_cyc_eye_y", 32'(eye_y), 32'd0);
        drive(0, 4'd0, 27'h0, 0, 1);
        drive(0, 4'd0, 27'h0, 0, 0);
        chk("next_fs_eye_y", 32'(eye_y), 32'h00AAAAA);

        // Writes and commits while PENDING are dropped.
        drive(0, 4'd0, 27'h0, 1, 0);
        drive(1, 4'd0, 27'd5, 1, 0);
        drive(0, 4'd0, 27'h0, 0, 1);
        drive(0, 4'd0, 27'h0, 0, 0);
        chk("drop_eye_x", 32'(eye_x), 32'h0123456);

        // Out-of-range write then a look_at write.
        drive(1, 4'd13, 27'h7FFFFFF, 0, 0);
        drive(0, 4'd0, 27'h0, 0, 0);
        drive(1, 4'd4, 27'h0001234, 0, 0);
        drive(0, 4'd0, 27'h0, 1, 0);
        drive(0, 4'd0, 27'h0, 0, 1);
        drive(0, 4'd0, 27'h0, 0, 0);
        chk("la12_pub", 32'(look_at_1_2), 32'h0001234);
        chk("addr13_eye_x", 32'(eye_x), 32'h0123456);

        // Frame counter wrap from a fresh reset.
        do_reset();
        for (int k = 0; k < 256; k++) drive(0, 4'd0, 27'h0, 0, 1);
        chk("fc_wrap", 32'(frame_count), 32'd0);

        // Reset mid-PENDING discards the commit and the staged values.
        drive(1, 4'd0, 27'h0000055, 0, 0);
        drive(1, 4'd3, 27'h0ABCDEF, 0, 0);
        drive(0, 4'd0, 27'h0, 1, 0);
        do_reset();
        chk("postrst_pending", 32'(cfg_pending), 32'd0);
        drive(0, 4'd0, 27'h0, 1, 0);
        drive(0, 4'd0, 27'h0, 0, 1);
        drive(0, 4'd0, 27'h0, 0, 0);
        chk("postrst_eye_x", 32'(eye_x), 32'd0);
        chk("postrst_la11", 32'(look_at_1_1), 32'(ONE));

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_param_regs.md
CAM_PARAM_REGS -- requirements
Module: cam_param_regs

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter DATA_W, default 27, SHALL set the camera word width (fp27: sign, 8-bit exponent, 18-bit mantissa).
REQ-003 Parameter FCNT_W, default 8, SHALL set the frame counter width.
REQ-004 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock (raymarcher clock domain)
- reset  in  1  asynchronous active-high reset
- wr_en  in  1  staging-register write request
- wr_addr  in  4  register index: 0-2 = eye_x/y/z; 3-11 = look_at row-major (3 = 1_1 ... 11 = 3_3)
- wr_data  in  DATA_W  write data
- wr_ready  out  1  high when writes are accepted
- wr_err  out  1  one-cycle pulse on an accepted write with wr_addr >= 12
- commit_req  in  1  request to publish the staged set
- frame_start  in  1  one-cycle pulse at display pixel (0,0)
- eye_x, eye_y, eye_z  out  DATA_W each  active eye position
- look_at_r_c (r,c in 1..3)  out  DATA_W each  active look-at matrix
- cfg_pending  out  1  commit waiting for a frame boundary
- params_updated  out  1  one-cycle pulse when the active set changes
- frame_count  out  FCNT_W  frame_start counter

Function
REQ-005 A write SHALL be accepted when wr_en && wr_ready, and SHALL update staging[wr_addr] on that edge.
REQ-006 Accepted writes to addresses 12-15 SHALL change no register and SHALL pulse wr_err on the next cycle.
REQ-007 The FSM SHALL have two states: IDLE (wr_ready = 1) and PENDING (wr_ready = 0, cfg_pending = 1).
REQ-008 IDLE SHALL go to PENDING on commit_req, and PENDING SHALL go to IDLE on frame_start.
REQ-009 On the PENDING-to-IDLE edge, all 12 active registers SHALL load from staging atomically, and params_updated SHALL pulse high the following cycle.
REQ-010 Active outputs SHALL be registered and SHALL change only on that edge (latency 1 clk from frame_start sampled in PENDING).
REQ-011 Simultaneous commit_req and frame_start in IDLE SHALL enter PENDING and SHALL publish at the next frame_start, not this one.
REQ-012 A write and commit_req in the same IDLE cycle SHALL include that write in the committed set.
REQ-013 commit_req in PENDING SHALL be ignored, and wr_en in PENDING SHALL be dropped (not queued).
REQ-014 frame_count SHALL increment on every frame_start in either state and SHALL wrap from 2^FCNT_W-1 to 0.
REQ-015 frame_start while IDLE SHALL leave all active registers unchanged.

Reset
REQ-016 While reset is high, the block SHALL hold state IDLE, wr_ready = 1, cfg_pending = 0, params_updated = 0, wr_err = 0, and frame_count = 0.
REQ-017 While reset is high, staging and active eye registers SHALL be 0, look_at diagonals SHALL be FP27_ONE (27'h1FC0000), and off-diagonals SHALL be 0.
REQ-018 Reset asserted mid-PENDING SHALL discard the pending commit and all staged values.

Configuration
REQ-019 With CAM_PARAM_READBACK_EN defined, the block SHALL add rd_addr (in, 4) and rd_data (out, DATA_W), where rd_data is the registered staging[rd_addr] one clk later, and addresses >= 12 read 0.
REQ-020 Without CAM_PARAM_READBACK_EN, those ports and their logic SHALL be absent.

Structure
REQ-021 Shared package cam_pkg SHALL hold FP27_ONE, the address constants ADDR_EYE_X..ADDR_LA_3_3, NUM_CAM_REGS = 12, and the state enum cam_state_t {IDLE, PENDING}.
REQ-022 The block SHALL contain no sub-module; the staging and active register arrays SHALL be inline, flattened to ports.

Verification
REQ-023 The bench SHALL check: reset release -> look_at_1_1 = 27'h1FC0000, look_at_1_2 = 0, eye_x = 0, wr_ready = 1.
REQ-024 The bench SHALL check: write eye_x = 27'h0123456, commit, frame_start -> eye_x = 27'h0123456 one clk later, params_updated pulses once, and cfg_pending drops.
REQ-025 The bench SHALL check: commit_req and frame_start in the same cycle -> no change; the next frame_start publishes.
REQ-026 The bench SHALL check: wr_en while PENDING with addr 0, data 5 -> dropped; staging and published eye_x keep the prior value.
REQ-027 The bench SHALL check: write to addr 13 -> wr_err pulses once and no register changes.
REQ-028 The bench SHALL check: 256 frame_start pulses -> frame_count returns to 0, and reset mid-PENDING -> cfg_pending = 0 and outputs at reset values.
